// File: rtl/seq_detector_param.sv
// seq_detector_param: serial bit-pattern detector with a run-time programmable
// pattern of 1..MAX_LEN bits, selectable overlapping detection and a saturating
// match counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset (0 = reset)
//   x            serial data bit
//   x_valid      x is sampled this cycle
//   cfg_load     latch cfg_* this cycle (wins over x_valid)
//   cfg_pattern  pattern; bit [len-1] is received first, bit [0] last
//   cfg_len      pattern length in bits
//   cfg_overlap  1 = overlapping detection
//   z            one-cycle match pulse (registered)
//   match_count  saturating match count (registered)
//   cfg_err      active configuration is invalid (registered)
module seq_detector_param #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0110),
  parameter int unsigned        DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int unsigned       LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam bit DefErr = (DEF_LEN == 0) || (DEF_LEN > MAX_LEN);

  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               err_q;
  logic               z_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;
  logic               load_err;

  always_comb begin
    hist_new = {hist_q[MAX_LEN-2:0], x};
    fill_inc = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    // Only the low len bits take part in the compare; the rest are don't-care.
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = x_valid && !err_q && (fill_inc >= len_q) &&
            (((hist_new ^ pat_q) & len_mask) == '0);
    load_err = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      err_q  <= DefErr;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else if (cfg_load) begin
      // Any x sampled alongside a load is dropped.
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= cfg_pattern;
      len_q  <= cfg_len;
      ovl_q  <= cfg_overlap;
      err_q  <= load_err;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      z_q <= 1'b0;
      if (x_valid) begin
        hist_q <= hist_new;
        // Non-overlap: forget the matched bits so none of them are reused.
        fill_q <= (match && !ovl_q) ? '0 : fill_inc;
        if (match) begin
          z_q <= 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param. A second instance with a
// 2-bit counter shares the stimulus and is checked only in the saturation test.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset;
  logic               x;
  logic               x_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               z;
  logic [7:0]         match_count;
  logic               cfg_err;
  logic               z2;
  logic [1:0]         match_count2;
  logic               cfg_err2;

  seq_detector_param dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .z           (z),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  seq_detector_param #(
    .CNT_W (2)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .z           (z2),
    .match_count (match_count2),
    .cfg_err     (cfg_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic     v;
    logic     xb;
    logic     ez;
    int       ec;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, then check the registered outputs 1 ns after the edge.
  task automatic step(input logic v, input logic xb, input logic ez, input int ec);
    x_valid = v;
    x       = xb;
    @(posedge clk);
    #1;
    chk("z", int'(z), int'(ez));
    chk("count", int'(match_count), ec);
    chk("cfg_err", int'(cfg_err), int'(exp_err));
  endtask

  task automatic push(input logic v, input logic xb, input logic ez, input int ec);
    vec_t r;
    r.v  = v;
    r.xb = xb;
    r.ez = ez;
    r.ec = ec;
    tbl.push_back(r);
  endtask

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].xb, tbl[i].ez, tbl[i].ec);
    end
    tbl.delete();
  endtask

  task automatic do_reset(input logic v, input logic xb);
    reset   = 1'b0;
    x_valid = v;
    x       = xb;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    x_valid = 1'b0;
    exp_err = 1'b0;
    chk("rst_z", int'(z), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
  endtask

  task automatic do_load(input logic [7:0] pat, input int len, input logic ov,
                         input logic err, input logic v, input logic xb);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ov;
    x_valid     = v;
    x           = xb;
    @(posedge clk);
    #1;
    cfg_load    = 1'b0;
    cfg_pattern = 8'hA5;  // junk: must not matter once loaded
    cfg_len     = '0;
    x_valid     = 1'b0;
    exp_err     = err;
    chk("load_z", int'(z), 0);
    chk("load_count", int'(match_count), 0);
    chk("load_cfg_err", int'(cfg_err), int'(err));
  endtask

  initial begin
    reset       = 1'b1;
    x           = 1'b0;
    x_valid     = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    @(negedge clk);

    // Defaults 0110, overlap.
    do_reset(1'b0, 1'b0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0); push(1, 0, 1, 1);
    push(1, 1, 0, 1); push(1, 1, 0, 1); push(1, 0, 1, 2);
    run_tbl();

    // 0110 without overlap.
    do_load(8'h06, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0); push(1, 0, 1, 1);
    push(1, 1, 0, 1); push(1, 1, 0, 1); push(1, 0, 0, 1);
    run_tbl();

    // 101 overlap with 3-cycle idle gaps; x toggled high during gaps.
    do_load(8'h05, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1, 1, 0, 0);
    for (int g = 0; g < 3; g++) push(0, 1, 0, 0);
    push(1, 0, 0, 0);
    for (int g = 0; g < 3; g++) push(0, 1, 0, 0);
    push(1, 1, 1, 1);
    for (int g = 0; g < 3; g++) push(0, 1, 0, 1);
    push(1, 0, 0, 1);
    for (int g = 0; g < 3; g++) push(0, 1, 0, 1);
    push(1, 1, 1, 2);
    run_tbl();

    // Invalid length: no matches, then recovery via a valid load.
    do_load(8'hFF, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(1, 1, 0, 0);
    run_tbl();
    do_load(8'hFF, 9, 1'b1, 1'b1, 1'b0, 1'b0);
    push(1, 1, 0, 0); push(1, 1, 0, 0);
    run_tbl();
    do_load(8'h03, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1, 1, 0, 0); push(1, 1, 1, 1);
    run_tbl();

    // len=1 back-to-back matches; 2-bit counter on dut2 saturates at 3.
    do_load(8'h01, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b1, i);
      chk("z2", int'(z2), 1);
      chk("count2", int'(match_count2), (i < 3) ? i : 3);
    end
    step(1'b1, 1'b0, 1'b0, 5);
    chk("z2_off", int'(z2), 0);

    // Reset mid-stream discards the partial match; next sample is bit 1.
    do_reset(1'b0, 1'b0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0);
    run_tbl();
    do_reset(1'b1, 1'b0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0); push(1, 0, 1, 1);
    run_tbl();

    // Load on the completing bit: no z, and history is cleared.
    do_reset(1'b0, 1'b0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0);
    run_tbl();
    do_load(8'h06, 4, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1, 0, 0, 0); push(1, 1, 0, 0); push(1, 1, 0, 0); push(1, 0, 1, 1);
    run_tbl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
